// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the instruction-fetch stage of the 5-stage MIPS
// pipeline: fetch state encoding, prefetch entry layout, NOP encoding and
// default parameters.
// Ports: none (package).
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

  // Fetch controller states.
  //   S_ISSUE : normal issue, request gated by FIFO credit
  //   S_BUSY  : request outstanding on the right path, waiting for ready
  //   S_DROP  : request outstanding on a wrong path, result is discarded
  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_BUSY  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int          FIFO_DEPTH_DEFAULT = 2;

  // One prefetch entry: fetched instruction plus the PC+4 that travels with it.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc_add;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request bus between the fetch unit and instruction memory.
// A transfer happens on a rising edge where IM_Req & IM_Ready are both high;
// IM_Data is returned in that same cycle.
// Signals:
//   IM_Req   fetch request (fetch unit -> memory)
//   IM_Addr  word address of the fetch, bits [1:0] always 0 (fetch unit -> memory)
//   IM_Ready memory accepts the request this cycle (memory -> fetch unit)
//   IM_Data  instruction word, valid with IM_Req & IM_Ready (memory -> fetch unit)
// Modports: master (fetch unit), slave (instruction memory).
// -----------------------------------------------------------------------------
interface if_fetch_unit_if;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ready;
  logic [31:0] IM_Data;

  modport master (
    output IM_Req,
    output IM_Addr,
    input  IM_Ready,
    input  IM_Data
  );

  modport slave (
    input  IM_Req,
    input  IM_Addr,
    output IM_Ready,
    output IM_Data
  );
endinterface

// File: rtl/if_fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Two-entry prefetch FIFO holding {IR, PC+4} pairs. The head is visible
// combinationally from the storage registers so the IF/ID register can sample
// it in the same cycle. A synchronous clear empties the FIFO in one edge.
// Ports:
//   clk        clock
//   srst       synchronous active-high reset
//   clear      synchronous flush (dominates push/pop)
//   push       write push_entry at the tail
//   pop        remove the head entry
//   push_entry entry to write
//   head_entry current head (undefined content when empty)
//   count      number of valid entries (0..2)
//   not_empty  count != 0
// -----------------------------------------------------------------------------
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head_entry,
  output logic [1:0]   count,
  output logic         not_empty
);

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  logic [0:0]   wr_ptr_reg;
  logic [0:0]   rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         do_push;
  logic         do_pop;
  fetch_entry_t entry_q [DEPTH];

  // Pop only real data; push only with room, where a same-edge pop makes room.
  assign do_pop  = pop & (count_reg != 2'd0) & ~clear;
  assign do_push = push & ~clear & ((count_reg != FULL_COUNT) | do_pop);

  // One storage register per slot; the write pointer selects which one loads.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      localparam logic [0:0] SLOT = 1'(gi);
      fetch_entry_t data_reg;

      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == SLOT)) begin
          data_reg <= push_entry;
        end
      end

      assign entry_q[gi] = data_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_entry = entry_q[rd_ptr_reg];
  assign count      = count_reg;
  assign not_empty  = (count_reg != 2'd0);

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. Owns the PC, issues word fetches to instruction
// memory, buffers returned words in a 2-entry prefetch FIFO and presents the
// head to the IF/ID register. Redirects flush the FIFO and discard any
// wrong-path fetch still in flight.
// Ports:
//   Clk          clock, rising edge
//   Reset        synchronous active-high reset
//   stall        hazard stall; when low the presented head is consumed
//   Redirect     taken branch / jump pulse
//   Redirect_PC  redirect target (bits [1:0] ignored)
//   im_bus       instruction-memory request bus (master side)
//   PC_Add       PC+4 of the presented instruction, 0 when empty
//   IR_out       presented instruction, NOP when empty
//   IF_Valid     FIFO non-empty
// -----------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  stall,
  input  logic                  Redirect,
  input  logic [31:0]           Redirect_PC,
  if_fetch_unit_if.master       im_bus,
  output logic [31:0]           PC_Add,
  output logic [31:0]           IR_out,
  output logic                  IF_Valid
);

  localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  drop_addr_reg, drop_addr_next;

  logic         req;
  logic [31:0]  addr;
  logic         xfer;
  logic [31:0]  pc_plus4;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_clear;
  logic [1:0]   fifo_count;
  logic         fifo_valid;
  fetch_entry_t fifo_head;
  fetch_entry_t push_entry;

  // ---------------------------------------------------------------------------
  // Request decode: only state, count and PC/Drop_Addr registers feed the bus,
  // so stall and Redirect never reach IM_Req/IM_Addr combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    req = 1'b0;
    case (state_reg)
      S_ISSUE: req = (fifo_count <= 2'd1);  // credit: room for one more word
      S_BUSY:  req = 1'b1;
      S_DROP:  req = 1'b1;
      default: req = 1'b0;
    endcase
    // Reset withdraws any request immediately.
    if (Reset) begin
      req = 1'b0;
    end
  end

  assign addr     = (state_reg == S_DROP) ? drop_addr_reg : pc_reg;
  assign xfer     = req & im_bus.IM_Ready;
  assign pc_plus4 = pc_reg + 32'd4;

  assign im_bus.IM_Req  = req;
  assign im_bus.IM_Addr = addr;

  assign push_entry = '{ir: im_bus.IM_Data, pc_add: pc_plus4};

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    drop_addr_next = drop_addr_reg;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    fifo_clear     = 1'b0;

    if (Redirect) begin
      // Redirect overrides push, pop and stall: flush and retarget.
      fifo_clear = 1'b1;
      pc_next    = word_align(Redirect_PC);
      case (state_reg)
        S_BUSY: begin
          if (xfer) begin
            state_next = S_ISSUE;
          end else begin
            // The pending wrong-path request must still complete; remember it.
            drop_addr_next = pc_reg;
            state_next     = S_DROP;
          end
        end
        S_DROP: begin
          // Drop_Addr stays; only the target PC moves.
          state_next = xfer ? S_ISSUE : S_DROP;
        end
        default: begin
          state_next = S_ISSUE;
        end
      endcase
    end else begin
      fifo_pop = ~stall & fifo_valid;
      case (state_reg)
        S_ISSUE: begin
          if (xfer) begin
            fifo_push = 1'b1;
            pc_next   = pc_plus4;
          end else if (req) begin
            state_next = S_BUSY;
          end
        end
        S_BUSY: begin
          if (xfer) begin
            fifo_push  = 1'b1;
            pc_next    = pc_plus4;
            state_next = S_ISSUE;
          end
        end
        S_DROP: begin
          if (xfer) begin
            state_next = S_ISSUE;
          end
        end
        default: begin
          state_next = S_ISSUE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= S_ISSUE;
      pc_reg        <= RESET_PC_ALIGNED;
      drop_addr_reg <= 32'h0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      drop_addr_reg <= drop_addr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO
  // ---------------------------------------------------------------------------
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk        (Clk),
    .srst       (Reset),
    .clear      (fifo_clear),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .push_entry (push_entry),
    .head_entry (fifo_head),
    .count      (fifo_count),
    .not_empty  (fifo_valid)
  );

  // Presented instruction: NOP and zero PC+4 when empty or in reset.
  assign IF_Valid = fifo_valid & ~Reset;
  assign IR_out   = IF_Valid ? fifo_head.ir     : NOP_INSTR;
  assign PC_Add   = IF_Valid ? fifo_head.pc_add : 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit. Stimulus pushes the expected consumed
// {PC_Add, address} pairs into a queue; a negedge monitor pops and compares
// whenever the IF/ID register would sample a valid head.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic [31:0] PC_Add;
  logic [31:0] IR_out;
  logic        IF_Valid;
  logic        ready_en;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc_add;
  } exp_t;

  exp_t exp_q[$];

  if_fetch_unit_if im_bus();

  // Instruction memory model: the word at address a is {16'h8C00, a[15:0]}.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'h8C00, a[15:0]};
  endfunction

  assign im_bus.IM_Ready = ready_en;
  assign im_bus.IM_Data  = mem_word(im_bus.IM_Addr);

  if_fetch_unit dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .stall       (stall),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .im_bus      (im_bus),
    .PC_Add      (PC_Add),
    .IR_out      (IR_out),
    .IF_Valid    (IF_Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
    n_checks++;
    if (act !== req_val) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req_val);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] pc4);
    exp_t e;
    e.addr   = a;
    e.pc_add = pc4;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: the IF/ID register consumes the head on an edge with ~stall.
  always @(negedge Clk) begin
    if (!Reset && !Redirect && !stall && IF_Valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_consume: got pc_add=%h ir=%h, required none", PC_Add, IR_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("consume pc_add=%h ir=%h (expected addr %h)", PC_Add, IR_out, e.addr);
        check("consume_ir", IR_out, mem_word(e.addr));
        check("consume_pc_add", PC_Add, e.pc_add);
      end
    end
  end

  initial begin
    #5000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset       = 1'b1;
    stall       = 1'b0;
    Redirect    = 1'b0;
    Redirect_PC = 32'h0;
    ready_en    = 1'b1;
    step(); step(); step();

    // Outputs held at zero while in reset
    check("rst_req", {31'h0, im_bus.IM_Req}, 32'h0);
    check("rst_valid", {31'h0, IF_Valid}, 32'h0);
    check("rst_ir", IR_out, 32'h0);
    check("rst_pc_add", PC_Add, 32'h0);

    // Reset release, ready tied high: 0, 4, 8 streamed
    Reset = 1'b0;
    push_exp(32'h00, 32'h04);
    push_exp(32'h04, 32'h08);
    push_exp(32'h08, 32'h0C);
    push_exp(32'h0C, 32'h10);
    #1;
    check("c0_addr", im_bus.IM_Addr, 32'h0);
    check("c0_req", {31'h0, im_bus.IM_Req}, 32'h1);
    step(); // c1
    check("c1_addr", im_bus.IM_Addr, 32'h4);
    check("c1_ir", IR_out, 32'h8C00_0000);
    check("c1_pc_add", PC_Add, 32'h4);
    step(); // c2
    check("c2_addr", im_bus.IM_Addr, 32'h8);
    check("c2_pc_add", PC_Add, 32'h8);
    step(); // c3
    check("c3_pc_add", PC_Add, 32'hC);

    // Stall held for 4 cycles: FIFO fills, request drops, head frozen
    stall = 1'b1;
    step(); // c4
    check("stall_req", {31'h0, im_bus.IM_Req}, 32'h0);
    check("stall_valid", {31'h0, IF_Valid}, 32'h1);
    check("stall_pc_add", PC_Add, 32'hC);
    step(); // c5
    step(); // c6
    check("stall_hold_pc_add", PC_Add, 32'hC);
    check("stall_hold_ir", IR_out, 32'h8C00_0008);
    step(); // c7
    stall = 1'b0;
    check("release_req", {31'h0, im_bus.IM_Req}, 32'h0);
    step(); // c8
    check("repop_req", {31'h0, im_bus.IM_Req}, 32'h1);
    check("repop_addr", im_bus.IM_Addr, 32'h10);
    check("repop_pc_add", PC_Add, 32'h10);

    // IM_Ready low for 3 cycles at 0x10
    ready_en = 1'b0;
    push_exp(32'h10, 32'h14);
    step(); // c9
    check("wait_req", {31'h0, im_bus.IM_Req}, 32'h1);
    check("wait_addr", im_bus.IM_Addr, 32'h10);
    check("wait_valid", {31'h0, IF_Valid}, 32'h0);
    check("wait_ir_nop", IR_out, 32'h0);
    step(); // c10
    check("wait2_addr", im_bus.IM_Addr, 32'h10);
    step(); // c11
    ready_en = 1'b1;
    check("wait3_addr", im_bus.IM_Addr, 32'h10);
    check("wait3_req", {31'h0, im_bus.IM_Req}, 32'h1);
    step(); // c12
    check("after_wait_ir", IR_out, 32'h8C00_0010);
    check("after_wait_pc_add", PC_Add, 32'h14);
    check("after_wait_addr", im_bus.IM_Addr, 32'h14);
    push_exp(32'h14, 32'h18);
    push_exp(32'h18, 32'h1C);
    push_exp(32'h1C, 32'h20);
    step(); // c13
    step(); // c14
    step(); // c15
    ready_en = 1'b0;
    check("busy_addr", im_bus.IM_Addr, 32'h20);

    // Redirect to 0x42 (aligned to 0x40) while S_BUSY at 0x20
    step(); // c16
    check("busy2_req", {31'h0, im_bus.IM_Req}, 32'h1);
    check("busy2_addr", im_bus.IM_Addr, 32'h20);
    check("busy2_valid", {31'h0, IF_Valid}, 32'h0);
    Redirect    = 1'b1;
    Redirect_PC = 32'h0000_0042;
    push_exp(32'h40, 32'h44);
    step(); // c17
    Redirect = 1'b0;
    check("drop_addr", im_bus.IM_Addr, 32'h20);
    check("drop_req", {31'h0, im_bus.IM_Req}, 32'h1);
    check("drop_valid", {31'h0, IF_Valid}, 32'h0);
    step(); // c18
    ready_en = 1'b1;
    check("drop2_addr", im_bus.IM_Addr, 32'h20);
    step(); // c19
    check("target_addr", im_bus.IM_Addr, 32'h40);
    check("target_valid", {31'h0, IF_Valid}, 32'h0);
    step(); // c20
    check("target_pc_add", PC_Add, 32'h44);
    check("target_ir", IR_out, 32'h8C00_0040);
    step(); // c21

    // Redirect with the FIFO full and stall held
    stall = 1'b1;
    step(); // c22
    check("full_req", {31'h0, im_bus.IM_Req}, 32'h0);
    check("full_valid", {31'h0, IF_Valid}, 32'h1);
    Redirect    = 1'b1;
    Redirect_PC = 32'h0000_0100;
    push_exp(32'h100, 32'h104);
    step(); // c23
    Redirect = 1'b0;
    check("flush_ir", IR_out, 32'h0);
    check("flush_valid", {31'h0, IF_Valid}, 32'h0);
    check("flush_req", {31'h0, im_bus.IM_Req}, 32'h1);
    check("flush_addr", im_bus.IM_Addr, 32'h100);
    step(); // c24
    stall = 1'b0;
    check("flush_pc_add", PC_Add, 32'h104);
    step(); // c25
    stall    = 1'b1;
    ready_en = 1'b0;
    check("pre_rst_addr", im_bus.IM_Addr, 32'h108);

    // Reset asserted while S_BUSY with one entry buffered
    step(); // c26
    check("busy_rst_req", {31'h0, im_bus.IM_Req}, 32'h1);
    check("busy_rst_addr", im_bus.IM_Addr, 32'h108);
    check("busy_rst_valid", {31'h0, IF_Valid}, 32'h1);
    Reset = 1'b1;
    #1;
    check("in_rst_req", {31'h0, im_bus.IM_Req}, 32'h0);
    check("in_rst_valid", {31'h0, IF_Valid}, 32'h0);
    check("in_rst_ir", IR_out, 32'h0);
    check("in_rst_pc_add", PC_Add, 32'h0);
    step(); // c27
    ready_en = 1'b1;
    check("in_rst2_req", {31'h0, im_bus.IM_Req}, 32'h0);
    step(); // c28
    Reset = 1'b0;
    stall = 1'b0;
    push_exp(32'h00, 32'h04);
    #1;
    check("restart_addr", im_bus.IM_Addr, 32'h0);
    check("restart_req", {31'h0, im_bus.IM_Req}, 32'h1);
    check("restart_valid", {31'h0, IF_Valid}, 32'h0);
    step(); // c29
    check("restart_pc_add", PC_Add, 32'h4);
    check("restart_ir", IR_out, 32'h8C00_0000);
    step(); // c30
    stall = 1'b1;
    step(); // c31
    check("exp_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. It owns the PC and issues word fetches to instruction memory over a req/ready handshake. Returned instructions go into a 2-entry prefetch FIFO. The FIFO head is presented as `PC_Add`/`IR_out`, and the IF/ID register samples it on every edge where `stall` is low. Control-transfer redirects from the branch/jump logic discard all wrong-path fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `FIFO_DEPTH`, default 2: prefetch entries. Fixed at 2; the credit rule below depends on it.

- `Clk`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit stall; the same signal drives IF/ID. When low, the head is consumed at the edge.
- `Redirect`  in  1  taken branch / j / jal / jr; one-cycle pulse.
- `Redirect_PC`  in  32  target address, valid when `Redirect` = 1.
- `IM_Req`  out  1  fetch request.
- `IM_Addr`  out  32  word address of the fetch; bits [1:0] always 0.
- `IM_Ready`  in  1  memory accepts the request and returns `IM_Data` in the same cycle.
- `IM_Data`  in  32  instruction word, valid when `IM_Req & IM_Ready`.
- `PC_Add`  out  32  PC+4 of the presented instruction; 0 when empty.
- `IR_out`  out  32  presented instruction; 32'h0 (NOP) when empty.
- `IF_Valid`  out  1  FIFO non-empty.

## Operation
- **Transfer:** a transfer occurs when `IM_Req & IM_Ready` is high at an edge. When `IM_Req` is high and `IM_Ready` is low, `IM_Addr` holds stable and `IM_Req` stays high until `IM_Ready` is seen.
- **Push:** a transfer in S_ISSUE or S_BUSY without `Redirect` pushes {`IM_Data`, PC+4} and sets PC <= PC+4. PC arithmetic is 32-bit and wraps modulo 2^32.
- **Pop:** the head is popped at an edge with `~stall & IF_Valid`. Push and pop can happen on the same edge; the count then stays unchanged.
- **Credit rule:** a new request may start only when count ≤ 1. While a request is outstanding no other push can occur, so the FIFO never overflows and the memory is never back-pressured.
- **States:**
  - S_ISSUE: `IM_Req` = (count ≤ 1), `IM_Addr` = PC.
    - Transfer: stay in S_ISSUE.
    - Request with no ready: go to S_BUSY.
  - S_BUSY: `IM_Req` = 1, `IM_Addr` = PC.
    - Ready: push, go to S_ISSUE.
  - S_DROP: `IM_Req` = 1, `IM_Addr` = `Drop_Addr`.
    - Ready: discard the data, go to S_ISSUE.
- **Redirect priority:** `Redirect` takes priority over push, pop and `stall`. On a redirect:
  - The FIFO is cleared and PC <= `Redirect_PC`.
  - In S_BUSY without ready: `Drop_Addr` <= PC, go to S_DROP.
  - Any transfer in the redirect cycle is discarded and the state goes to S_ISSUE.
  - In S_DROP: stay in S_DROP, update PC only.
- `Redirect_PC` bits [1:0] are forced to 0.
- **Reset:** PC <= `RESET_PC`, count <= 0, state <= S_ISSUE, `Drop_Addr` <= 0. While `Reset` is high: `IM_Req` = 0, `PC_Add` = 0, `IR_out` = 0, `IF_Valid` = 0. Reset mid-request withdraws the request, and instruction memory must tolerate this.

## Timing
- Fetch latency: an address accepted at edge N is presented on `IR_out` during cycle N+1.
- With `IM_Ready` tied high and no stalls, throughput is 1 instruction/cycle and count stays at 1.
- With `stall` held, the FIFO fills to 2 and `IM_Req` drops. It reasserts the cycle after the first pop.
- Redirect at edge N: `IM_Addr` = target in cycle N+1, except in S_DROP, where the first target fetch is issued the cycle after the dropped transfer.
- All outputs are driven from registers plus count/state decode. No combinational path runs from `stall` or `Redirect` to `IM_Req`/`IM_Addr`.

## Structure
- Shared pipeline package: state encoding (S_ISSUE, S_BUSY, S_DROP), `NOP_INSTR` = 32'h0, `RESET_PC` default.
- One sub-module: `fetch_fifo`, a 2-entry FIFO with a synchronous clear, 64-bit entries {IR, PC+4}, push/pop/clear and count. The PC, state machine and `Drop_Addr` stay in `if_fetch_unit`.

## Test plan
- **Reset release, `IM_Ready` = 1:** `IM_Addr` sequence 0, 4, 8; `IR_out` follows one cycle later; `PC_Add` = 4, 8, 12.
- **Stall held 4 cycles with `IM_Ready` = 1:** count reaches 2, then `IM_Req` = 0; the presented word is unchanged. On release, words appear in order with no gap or duplicate.
- **`IM_Ready` low 3 cycles at address 0x10:** `IM_Req` and `IM_Addr` are held at 0x10 throughout; `IF_Valid` goes low once the FIFO drains; the word at 0x10 is presented after ready.
- **`Redirect` to 0x40 while S_BUSY at 0x20:**
  - The state enters S_DROP; `IM_Addr` stays 0x20 until ready.
  - The 0x20 data is never presented.
  - The next request is to 0x40.
- **`Redirect` with the FIFO full and `stall` = 1:** the FIFO is cleared the next cycle, `IR_out` = 0, and the fetch at `Redirect_PC` starts immediately.
- **`Reset` asserted mid-S_BUSY:** `IM_Req` = 0 and all outputs are 0 while reset is high; fetch restarts at `RESET_PC`.
